// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter onto a single shared slave port.
// Round-robin grant, held for the whole master cycle, with a watchdog
// that answers a silent slave with a one-cycle error to the granted master.
module wb_arbiter_2 #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,

  output logic [1:0]              gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TMO   = 2'd2
  } state_t;

  localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

  state_t      state, state_next;
  logic [1:0]  gnt_next;
  logic        last_m1, last_m1_next;   // 1: master 1 was granted most recently
  logic [15:0] wd_cnt, wd_cnt_next;

  logic        g_cyc;
  logic        g_stb;
  logic        slv_term;

  assign g_cyc    = (gnt[0] & wbm0_cyc_i) | (gnt[1] & wbm1_cyc_i);
  assign g_stb    = (gnt[0] & wbm0_stb_i) | (gnt[1] & wbm1_stb_i);
  assign slv_term = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // State, grant, round-robin history and watchdog registers.
  // last_m1 resets to 1 so that master 0 wins the first contested request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      last_m1 <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      last_m1 <= last_m1_next;
      wd_cnt  <= wd_cnt_next;
    end
  end

  // Next-state: arbitrate in IDLE, hold grant while cyc stays high, run watchdog.
  // TMO is entered when the increment would reach TIMEOUT, so a termination in
  // that same cycle suppresses the timeout.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    last_m1_next = last_m1;
    wd_cnt_next  = '0;
    unique case (state)
      IDLE: begin
        if (wbm0_cyc_i || wbm1_cyc_i) begin
          state_next = GRANT;
          if (wbm0_cyc_i && (!wbm1_cyc_i || last_m1)) begin
            gnt_next     = 2'b01;
            last_m1_next = 1'b0;
          end else begin
            gnt_next     = 2'b10;
            last_m1_next = 1'b1;
          end
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else if (g_stb && !slv_term) begin
          if (({1'b0, wd_cnt} + 17'd1) >= TIMEOUT_CNT) begin
            state_next = TMO;
          end else begin
            wd_cnt_next = wd_cnt + 16'd1;
          end
        end
      end
      TMO: begin
        if (!g_cyc) begin
          state_next = IDLE;
          gnt_next   = '0;
        end else begin
          state_next = GRANT;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // Slave-side mux and termination routing to the granted master.
  always_comb begin
    wbs_adr_o  = gnt[1] ? wbm1_adr_i : wbm0_adr_i;
    wbs_dat_o  = gnt[1] ? wbm1_dat_i : wbm0_dat_i;
    wbs_we_o   = gnt[1] ? wbm1_we_i  : wbm0_we_i;
    wbs_sel_o  = gnt[1] ? wbm1_sel_i : wbm0_sel_i;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    if (state == GRANT) begin
      wbs_cyc_o  = g_cyc;
      wbs_stb_o  = g_stb;
      wbm0_ack_o = gnt[0] & wbs_ack_i;
      wbm0_err_o = gnt[0] & wbs_err_i;
      wbm0_rty_o = gnt[0] & wbs_rty_i;
      wbm1_ack_o = gnt[1] & wbs_ack_i;
      wbm1_err_o = gnt[1] & wbs_err_i;
      wbm1_rty_o = gnt[1] & wbs_rty_i;
    end else if (state == TMO) begin
      wbm0_err_o = gnt[0];
      wbm1_err_o = gnt[1];
    end
  end

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Testbench for wb_arbiter_2: directed scenarios plus a random phase, all
// checked cycle by cycle against a rule-level reference model via a queue.
module tb_wb_arbiter_2;

  localparam int DW      = 64;
  localparam int AW      = 32;
  localparam int SW      = DW / 8;
  localparam int TMO_CYC = 4;

  logic clk;
  logic rst;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];

  logic [DW-1:0] rdat0, rdat1;
  logic          ack0, err0, rty0, ack1, err1, rty1;

  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic          s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
  logic [SW-1:0] s_sel;
  logic [1:0]    gnt;

  wb_arbiter_2 #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .SELECT_WIDTH(SW),
    .TIMEOUT     (TMO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wbm0_adr_i(m_adr[0]),
    .wbm0_dat_i(m_dat[0]),
    .wbm0_dat_o(rdat0),
    .wbm0_we_i (m_we[0]),
    .wbm0_sel_i(m_sel[0]),
    .wbm0_stb_i(m_stb[0]),
    .wbm0_cyc_i(m_cyc[0]),
    .wbm0_ack_o(ack0),
    .wbm0_err_o(err0),
    .wbm0_rty_o(rty0),
    .wbm1_adr_i(m_adr[1]),
    .wbm1_dat_i(m_dat[1]),
    .wbm1_dat_o(rdat1),
    .wbm1_we_i (m_we[1]),
    .wbm1_sel_i(m_sel[1]),
    .wbm1_stb_i(m_stb[1]),
    .wbm1_cyc_i(m_cyc[1]),
    .wbm1_ack_o(ack1),
    .wbm1_err_o(err1),
    .wbm1_rty_o(rty1),
    .wbs_adr_o (s_adr),
    .wbs_dat_i (s_rdat),
    .wbs_dat_o (s_wdat),
    .wbs_we_o  (s_we),
    .wbs_sel_o (s_sel),
    .wbs_stb_o (s_stb),
    .wbs_ack_i (s_ack),
    .wbs_err_i (s_err),
    .wbs_rty_i (s_rty),
    .wbs_cyc_o (s_cyc),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    gnt;
    logic          scyc, sstb, mux;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic [SW-1:0] sel;
    logic [1:0]    ack, err, rty;
    logic [DW-1:0] sdat;
  } exp_t;

  exp_t exp_q [$];
  exp_t me;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether this cycle is the timeout cycle,
  // who was granted last, and how many unterminated strobe cycles have elapsed.
  int owner;
  bit tmo;
  int last;
  int wd;

  // Master and slave stimulus state.
  bit       rst_prev;
  bit       rand_mode;
  bit [1:0] prev_term;
  int m_budget [2];
  int m_ntx_cfg [2];
  int m_left [2];
  int m_delay [2];
  int m_delay_cfg [2];
  int s_cnt, s_k, s_kind, cfg_k;

  int obs_ack [2];
  int obs_err [2];
  int obs_rty [2];
  logic [1:0] gnt_log [$];
  logic [1:0] gnt_prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_txn(input int i);
    m_adr[i] = AW'($urandom);
    m_dat[i] = DW'({$urandom, $urandom});
    m_we[i]  = 1'($urandom_range(0, 1));
    m_sel[i] = SW'($urandom);
  endtask

  task automatic step(input bit r);
    exp_t e;
    bit act, sterm;
    bit sa, se, sr;
    @(posedge clk);
    #1;
    rst = r;
    for (int i = 0; i < 2; i++) begin
      if (rst_prev) begin
        m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_budget[i] = 0; m_left[i] = 0;
      end else if (m_cyc[i]) begin
        if (prev_term[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            m_delay[i] = rand_mode ? int'($urandom_range(0, 3)) : m_delay_cfg[i];
          end else begin
            new_txn(i);
            m_stb[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
        end else if (!m_stb[i]) begin
          m_stb[i] = ($urandom_range(0, 1) == 1);
        end
      end else if (m_budget[i] > 0) begin
        if (m_delay[i] > 0) m_delay[i]--;
        else begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1; new_txn(i);
          m_left[i] = rand_mode ? int'($urandom_range(1, 4)) : m_ntx_cfg[i];
          m_budget[i]--;
        end
      end
    end
    #1;
    sa = 0; se = 0; sr = 0; sterm = 0;
    act = (owner >= 0) && !tmo && m_cyc[owner] && m_stb[owner];
    if (act) begin
      if (s_cnt == 0) begin
        s_k = (cfg_k > 0) ? cfg_k : int'($urandom_range(1, 6));
        s_kind = rand_mode ? int'($urandom_range(0, 5)) : 0;
      end
      sterm = (s_cnt + 1 == s_k);
      if (sterm) begin
        if (s_kind == 4) se = 1;
        else if (s_kind == 5) sr = 1;
        else sa = 1;
      end
      s_cnt = sterm ? 0 : s_cnt + 1;
    end else begin
      s_cnt = 0;
      if (rand_mode && (owner < 0 || tmo) && $urandom_range(0, 7) == 0) begin
        sa = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
      end
    end
    s_ack = sa; s_err = se; s_rty = sr;
    s_rdat = DW'({$urandom, $urandom});

    e.gnt = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    e.scyc = 0; e.sstb = 0; e.mux = 0; e.adr = '0; e.dat = '0; e.we = 0; e.sel = '0;
    e.ack = '0; e.err = '0; e.rty = '0; e.sdat = s_rdat;
    if (owner >= 0 && !tmo) begin
      e.scyc = m_cyc[owner]; e.sstb = m_stb[owner]; e.mux = 1;
      e.adr = m_adr[owner]; e.dat = m_dat[owner]; e.we = m_we[owner]; e.sel = m_sel[owner];
      e.ack[owner] = sa; e.err[owner] = se; e.rty[owner] = sr;
    end else if (owner >= 0) begin
      e.err[owner] = 1'b1;
    end
    exp_q.push_back(e);
    prev_term = e.ack | e.err | e.rty;

    if (r) begin
      owner = -1; tmo = 0; last = 1; wd = 0;
    end else if (owner < 0) begin
      if (m_cyc != 2'b00) begin
        if (m_cyc == 2'b11) owner = (last == 0) ? 1 : 0;
        else owner = m_cyc[0] ? 0 : 1;
        last = owner; wd = 0;
      end
    end else if (tmo) begin
      tmo = 0;
      if (!m_cyc[owner]) owner = -1;
    end else if (!m_cyc[owner]) begin
      owner = -1; wd = 0;
    end else if (m_stb[owner] && !(sa || se || sr)) begin
      wd++;
      if (wd == TMO_CYC) begin tmo = 1; wd = 0; end
    end else begin
      wd = 0;
    end
    rst_prev = r;
  endtask

  task automatic reset_bus();
    step(1'b1);
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      obs_ack[i] = 0; obs_err[i] = 0; obs_rty[i] = 0;
    end
    gnt_log.delete();
  endtask

  task automatic run_until_done(input int maxc);
    int n = 0;
    while ((m_budget[0] > 0 || m_budget[1] > 0 || m_cyc != 2'b00 || owner >= 0) && n < maxc) begin
      step(1'b0);
      n++;
    end
    chk("wait_bound", 128'(n < maxc), 128'd1);
    step(1'b0);
    step(1'b0);
  endtask

  task automatic setup(input int i, input int budget, input int ntx, input int delay);
    m_budget[i] = budget; m_ntx_cfg[i] = ntx; m_delay[i] = delay; m_delay_cfg[i] = delay;
  endtask

  task automatic chk_log(input string name, input int n, input logic [7:0] pat);
    logic [7:0] p;
    p = pat;
    chk({name, "_len"}, 128'(gnt_log.size()), 128'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++) chk(name, 128'(gnt_log[i]), 128'(p[2*i +: 2]));
  endtask

  // Monitor: pop the predicted response for every cycle and compare every output.
  initial begin
    gnt_prev = 2'b00;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        me = exp_q.pop_front();
        chk("gnt", 128'(gnt), 128'(me.gnt));
        chk("wbs_cyc", 128'(s_cyc), 128'(me.scyc));
        chk("wbs_stb", 128'(s_stb), 128'(me.sstb));
        chk("m_ack", 128'({ack1, ack0}), 128'(me.ack));
        chk("m_err", 128'({err1, err0}), 128'(me.err));
        chk("m_rty", 128'({rty1, rty0}), 128'(me.rty));
        chk("m0_dat_o", 128'(rdat0), 128'(me.sdat));
        chk("m1_dat_o", 128'(rdat1), 128'(me.sdat));
        if (me.mux) begin
          chk("wbs_adr", 128'(s_adr), 128'(me.adr));
          chk("wbs_dat", 128'(s_wdat), 128'(me.dat));
          chk("wbs_we", 128'(s_we), 128'(me.we));
          chk("wbs_sel", 128'(s_sel), 128'(me.sel));
        end
        obs_ack[0] += int'(ack0); obs_ack[1] += int'(ack1);
        obs_err[0] += int'(err0); obs_err[1] += int'(err1);
        obs_rty[0] += int'(rty0); obs_rty[1] += int'(rty1);
        if (gnt != 2'b00 && gnt != gnt_prev) gnt_log.push_back(gnt);
        gnt_prev = gnt;
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
      m_budget[i] = 0; m_ntx_cfg[i] = 1; m_left[i] = 0; m_delay[i] = 0; m_delay_cfg[i] = 0;
    end
    s_ack = 0; s_err = 0; s_rty = 0; s_rdat = '0;
    owner = -1; tmo = 0; last = 1; wd = 0;
    rst_prev = 0; rand_mode = 0; prev_term = '0;
    s_cnt = 0; s_k = 1; s_kind = 0; cfg_k = 2;

    reset_bus();
    chk("reset_gnt", 128'(gnt), 128'd0);
    chk("reset_cyc", 128'(s_cyc), 128'd0);

    // Single master, slave answers on the second strobe cycle.
    cfg_k = 2;
    setup(0, 1, 1, 0);
    run_until_done(100);
    chk("a_m0_ack", 128'(obs_ack[0]), 128'd1);
    chk("a_m1_terms", 128'(obs_ack[1] + obs_err[1] + obs_rty[1]), 128'd0);
    chk_log("a_gnt", 1, 8'b0000_0001);

    // Simultaneous requests from reset alternate 01,10,01,10.
    reset_bus();
    cfg_k = 1;
    setup(0, 2, 1, 0);
    setup(1, 2, 1, 0);
    run_until_done(200);
    chk_log("b_gnt", 4, 8'b1001_1001);

    // Four back-to-back transfers by m0 are not preempted by m1.
    reset_bus();
    cfg_k = 1;
    setup(0, 1, 4, 0);
    setup(1, 1, 1, 1);
    run_until_done(200);
    chk_log("c_gnt", 2, 8'b0000_1001);
    chk("c_m0_ack", 128'(obs_ack[0]), 128'd4);
    chk("c_m1_ack", 128'(obs_ack[1]), 128'd1);

    // Silent slave: every transfer ends in a watchdog error.
    reset_bus();
    cfg_k = 99;
    setup(0, 1, 2, 0);
    run_until_done(200);
    chk("d1_m0_err", 128'(obs_err[0]), 128'd2);
    chk("d1_m0_ack", 128'(obs_ack[0]), 128'd0);

    // Ack on the TIMEOUT-th strobe cycle wins over the watchdog.
    reset_bus();
    cfg_k = TMO_CYC;
    setup(0, 1, 2, 0);
    run_until_done(200);
    chk("d2_m0_ack", 128'(obs_ack[0]), 128'd2);
    chk("d2_m0_err", 128'(obs_err[0]), 128'd0);

    // One cycle later is too late.
    reset_bus();
    cfg_k = TMO_CYC + 1;
    setup(0, 1, 2, 0);
    run_until_done(200);
    chk("d3_m0_err", 128'(obs_err[0]), 128'd2);
    chk("d3_m0_ack", 128'(obs_ack[0]), 128'd0);

    // Reset while m1 owns the bus mid-transfer.
    reset_bus();
    cfg_k = 99;
    setup(1, 1, 1, 0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("e_gnt_after_rst", 128'(gnt), 128'd0);
    chk("e_cyc_after_rst", 128'(s_cyc), 128'd0);
    chk("e_m1_terms", 128'(obs_ack[1] + obs_err[1] + obs_rty[1]), 128'd0);
    cfg_k = 1;
    setup(0, 1, 1, 0);
    setup(1, 1, 1, 0);
    run_until_done(200);
    chk_log("e_gnt", 3, 8'b0010_0110);
    chk("e_m1_ack", 128'(obs_ack[1]), 128'd1);

    // Random traffic, latencies both sides of the watchdog, stray terminations.
    reset_bus();
    rand_mode = 1;
    cfg_k = 0;
    setup(0, 30, 1, 0);
    setup(1, 30, 1, 0);
    run_until_done(20000);
    rand_mode = 0;

    @(negedge clk);
    #1;
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
